// File: rtl/plab5_mcore_mem_sec_arbiter.sv
// ============================================================================
// Module      : plab5_mcore_mem_sec_arbiter
// Description : Round-robin arbiter sharing one memory port between a
//               non-secure (port 0) and a secure (port 1) requester, with
//               domain tagging and owner-only response routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plab5_mcore_mem_sec_arbiter #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int req_nbits      = 3 + p_opaque_nbits + p_addr_nbits
                                 + $clog2(p_data_nbits/8) + p_data_nbits,
  parameter int resp_nbits     = 3 + p_opaque_nbits + 2
                                 + $clog2(p_data_nbits/8) + p_data_nbits
)(
  input  logic                  clk,
  input  logic                  reset,

  input  logic [req_nbits-1:0]  req0_msg,
  input  logic                  req0_val,
  output logic                  req0_rdy,
  output logic [resp_nbits-1:0] resp0_msg,
  output logic                  resp0_val,
  input  logic                  resp0_rdy,

  input  logic [req_nbits-1:0]  req1_msg,
  input  logic                  req1_val,
  output logic                  req1_rdy,
  output logic [resp_nbits-1:0] resp1_msg,
  output logic                  resp1_val,
  input  logic                  resp1_rdy,

  output logic [req_nbits-1:0]  mem_req_msg,
  output logic                  mem_req_val,
  input  logic                  mem_req_rdy,
  output logic                  mem_req_domain,

  input  logic [resp_nbits-1:0] mem_resp_msg,
  input  logic                  mem_resp_val,
  output logic                  mem_resp_rdy,
  output logic                  mem_resp_domain,

  output logic                  busy
);

  localparam logic [1:0] c_STATE_IDLE   = 2'd0;
  localparam logic [1:0] c_STATE_REQ    = 2'd1;
  localparam logic [1:0] c_STATE_RESP   = 2'd2;
  localparam logic [1:0] c_STATE_UNUSED = 2'd3;

  logic [1:0]           r_state;
  logic                 r_prio;
  logic                 r_owner;
  logic [req_nbits-1:0] r_msg;

  logic                 w_in_idle;
  logic                 w_in_req;
  logic                 w_in_resp;
  logic                 w_any_val;
  logic                 w_grant;
  logic                 w_req_fire;
  logic                 w_mem_req_fire;
  logic                 w_mem_resp_fire;

  assign w_in_idle = (r_state == c_STATE_IDLE);
  assign w_in_req  = (r_state == c_STATE_REQ);
  assign w_in_resp = (r_state == c_STATE_RESP);
  assign w_any_val = req0_val | req1_val;

  // Priority port wins when it is valid; otherwise the other port (if valid).
  always_comb begin
    w_grant = r_prio;
    if (r_prio == 1'b0) begin
      w_grant = req0_val ? 1'b0 : 1'b1;
    end else begin
      w_grant = req1_val ? 1'b1 : 1'b0;
    end
  end

  // Every handshake output is held low while reset is asserted, even if the
  // state register still holds a mid-transaction value.
  assign req0_rdy = !reset && w_in_idle && w_any_val && (w_grant == 1'b0);
  assign req1_rdy = !reset && w_in_idle && w_any_val && (w_grant == 1'b1);

  assign mem_req_val     = !reset && w_in_req;
  assign mem_req_msg     = r_msg;
  assign mem_req_domain  = r_owner;
  assign mem_resp_domain = r_owner;

  assign mem_resp_rdy = !reset && w_in_resp && (r_owner ? resp1_rdy : resp0_rdy);

  assign resp0_val = !reset && w_in_resp && !r_owner && mem_resp_val;
  assign resp1_val = !reset && w_in_resp &&  r_owner && mem_resp_val;
  assign resp0_msg = (w_in_resp && !r_owner) ? mem_resp_msg : '0;
  assign resp1_msg = (w_in_resp &&  r_owner) ? mem_resp_msg : '0;

  assign busy = !reset && !w_in_idle;

  assign w_req_fire      = (req0_val && req0_rdy) || (req1_val && req1_rdy);
  assign w_mem_req_fire  = mem_req_val && mem_req_rdy;
  assign w_mem_resp_fire = mem_resp_val && mem_resp_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_STATE_IDLE;
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_msg   <= '0;
    end else begin
      case (r_state)
        c_STATE_IDLE: begin
          if (w_req_fire) begin
            r_msg   <= w_grant ? req1_msg : req0_msg;
            r_owner <= w_grant;
            r_prio  <= ~w_grant;
            r_state <= c_STATE_REQ;
          end
        end
        c_STATE_REQ: begin
          if (w_mem_req_fire) begin
            r_state <= c_STATE_RESP;
          end
        end
        c_STATE_RESP: begin
          if (w_mem_resp_fire) begin
            r_state <= c_STATE_IDLE;
          end
        end
        c_STATE_UNUSED: begin
          r_state <= c_STATE_IDLE;
        end
        default: begin
          r_state <= c_STATE_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
